// File: rtl/id_ex_stage.sv
// id_ex_stage: pipeline register between instruction decode and the ALU.
// Decodes opcode/funct into a 3-bit ALU select code, builds both ALU
// operands (immediate extension plus EX/MEM and MEM/WB forwarding),
// detects load-use hazards and registers everything for the EX stage.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid                     decode slot holds a real instruction
//   opcode, funct, shamt, imm16  instruction fields
//   rs, rt, rd                   register indices
//   rs_data, rt_data             register-file read data
//   exmem_we/rd/data             EX/MEM writeback info (forwarding source)
//   memwb_we/rd/data             MEM/WB writeback info (forwarding source)
//   hold                         downstream stall, freeze all registers
//   flush                        branch taken, load a bubble
//   out_*                        registered ALU inputs and control flags
//   load_stall                   combinational, decode must hold its instruction
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm16,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_sel,
  output logic [4:0]        out_shamt,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_branch,
  output logic              out_illegal,
  output logic              load_stall
);

  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_SUB  = 3'd1;
  localparam logic [2:0] SEL_SLL  = 3'd2;
  localparam logic [2:0] SEL_SRL  = 3'd3;
  localparam logic [2:0] SEL_AND  = 3'd4;
  localparam logic [2:0] SEL_OR   = 3'd5;
  localparam logic [2:0] SEL_SLT  = 3'd6;
  localparam logic [2:0] SEL_SLTU = 3'd7;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        sel;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic              illegal;
  } stage_t;

  // Register 0 is hard-wired to zero and never forwarded; EX/MEM is younger
  // than MEM/WB, so it wins when both target the same register.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    if (r == {REG_AW{1'b0}}) begin
      fwd = {DATA_W{1'b0}};
    end else if (ex_we && (ex_rd == r)) begin
      fwd = ex_data;
    end else if (wb_we && (wb_rd == r)) begin
      fwd = wb_data;
    end else begin
      fwd = rf_data;
    end
  endfunction

  stage_t            stage_r;
  stage_t            dec_s;
  stage_t            nxt_s;
  logic              dec_legal_s;
  logic              reads_rt_s;
  logic [DATA_W-1:0] fwd_rs_s;
  logic [DATA_W-1:0] fwd_rt_s;
  logic [DATA_W-1:0] imm_sext_s;
  logic [DATA_W-1:0] imm_zext_s;

  assign fwd_rs_s   = fwd(rs, rs_data, exmem_we, exmem_rd, exmem_data,
                          memwb_we, memwb_rd, memwb_data);
  assign fwd_rt_s   = fwd(rt, rt_data, exmem_we, exmem_rd, exmem_data,
                          memwb_we, memwb_rd, memwb_data);
  assign imm_sext_s = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext_s = {{(DATA_W-16){1'b0}}, imm16};

  // Instruction decode: select code, operands, destination and control flags.
  always_comb begin
    dec_s       = '0;
    dec_s.valid = 1'b1;
    dec_s.a     = fwd_rs_s;
    dec_s.b     = fwd_rt_s;
    dec_s.dest  = rt;
    dec_legal_s = 1'b1;
    reads_rt_s  = 1'b0;
    case (opcode)
      6'h00: begin
        dec_s.dest     = rd;
        dec_s.regwrite = 1'b1;
        reads_rt_s     = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_s.sel = SEL_ADD;
          6'h22, 6'h23: dec_s.sel = SEL_SUB;
          6'h24:        dec_s.sel = SEL_AND;
          6'h25:        dec_s.sel = SEL_OR;
          6'h2A:        dec_s.sel = SEL_SLT;
          6'h2B:        dec_s.sel = SEL_SLTU;
          6'h00, 6'h02: begin
            // Shifts operate on rt; rs is unused.
            dec_s.sel   = (funct == 6'h00) ? SEL_SLL : SEL_SRL;
            dec_s.a     = fwd_rt_s;
            dec_s.shamt = shamt;
          end
          default:      dec_legal_s = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec_s.sel = SEL_ADD; dec_s.b = imm_sext_s; dec_s.regwrite = 1'b1;
      end
      6'h0A: begin
        dec_s.sel = SEL_SLT; dec_s.b = imm_sext_s; dec_s.regwrite = 1'b1;
      end
      6'h0B: begin
        // Unsigned compare against the sign-extended immediate.
        dec_s.sel = SEL_SLTU; dec_s.b = imm_sext_s; dec_s.regwrite = 1'b1;
      end
      6'h0C: begin
        dec_s.sel = SEL_AND; dec_s.b = imm_zext_s; dec_s.regwrite = 1'b1;
      end
      6'h0D: begin
        dec_s.sel = SEL_OR; dec_s.b = imm_zext_s; dec_s.regwrite = 1'b1;
      end
      6'h23: begin
        dec_s.b = imm_sext_s; dec_s.memread = 1'b1; dec_s.regwrite = 1'b1;
      end
      6'h2B: begin
        dec_s.b = imm_sext_s; dec_s.memwrite = 1'b1; reads_rt_s = 1'b1;
      end
      6'h04: begin
        dec_s.sel = SEL_SUB; dec_s.branch = 1'b1; reads_rt_s = 1'b1;
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // A load in EX whose destination is read by the decode instruction cannot
  // be forwarded in time, so decode holds and EX takes a bubble.
  assign load_stall = stage_r.valid & stage_r.memread &
                      (stage_r.dest != {REG_AW{1'b0}}) & in_valid &
                      ((stage_r.dest == rs) | ((stage_r.dest == rt) & reads_rt_s));

  // Next register contents: the decoded instruction, or a bubble (all zero),
  // flagged illegal when a real, non-stalled instruction fails to decode.
  always_comb begin
    nxt_s = '0;
    if (in_valid && !load_stall && dec_legal_s) begin
      nxt_s = dec_s;
    end else if (in_valid && !load_stall) begin
      nxt_s.illegal = 1'b1;
    end else begin
      nxt_s.illegal = 1'b0;
    end
  end

  // Stage register: flush beats hold, hold freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_r <= '0;
    end else if (flush) begin
      stage_r <= '0;
    end else if (!hold) begin
      stage_r <= nxt_s;
    end
  end

  assign out_valid    = stage_r.valid;
  assign out_a        = stage_r.a;
  assign out_b        = stage_r.b;
  assign out_sel      = stage_r.sel;
  assign out_shamt    = stage_r.shamt;
  assign out_dest     = stage_r.dest;
  assign out_regwrite = stage_r.regwrite;
  assign out_memread  = stage_r.memread;
  assign out_memwrite = stage_r.memwrite;
  assign out_branch   = stage_r.branch;
  assign out_illegal  = stage_r.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expected stage contents are pushed to
// a scoreboard queue when an instruction is driven and popped one cycle later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [4:0]  sh;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk, reset_n, in_valid, hold, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rs, rt, rd, exmem_rd, memwb_rd;
  logic [31:0] rs_data, rt_data, exmem_data, memwb_data;
  logic [15:0] imm16;
  logic        exmem_we, memwb_we;
  logic        out_valid, out_regwrite, out_memread, out_memwrite, out_branch;
  logic        out_illegal, load_stall;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_sel;
  logic [4:0]  out_shamt, out_dest;

  exp_t q[$];
  exp_t bub;
  exp_t ill;
  int   checks = 0;
  int   passes = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .funct(funct), .shamt(shamt), .rs(rs), .rt(rt), .rd(rd),
    .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .hold(hold), .flush(flush), .out_valid(out_valid), .out_a(out_a),
    .out_b(out_b), .out_sel(out_sel), .out_shamt(out_shamt),
    .out_dest(out_dest), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_branch(out_branch), .out_illegal(out_illegal),
    .load_stall(load_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [31:0] a, b,
                              input logic [2:0] sel, input logic [4:0] sh, dest,
                              input logic rw, mr, mw, br, il);
    mk = {v, a, b, sel, sh, dest, rw, mr, mw, br, il};
  endfunction

  task automatic push(input exp_t e);
    q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e, o;
    o = {out_valid, out_a, out_b, out_sel, out_shamt, out_dest, out_regwrite,
         out_memread, out_memwrite, out_branch, out_illegal};
    checks++;
    if (q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = q.pop_front();
      assert (o === e) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_stall(input string tag, input logic e);
    checks++;
    assert (load_stall === e) passes++;
    else $error("FAIL %s: load_stall observed %b expected %b", tag, load_stall, e);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic r_op(input logic [5:0] f, input logic [4:0] s, t, d,
                      input logic [31:0] sd, td, input logic [4:0] sh);
    in_valid = 1'b1; opcode = 6'h00; funct = f; rs = s; rt = t; rd = d;
    rs_data = sd; rt_data = td; shamt = sh; imm16 = 16'h0000;
  endtask

  task automatic i_op(input logic [5:0] op, input logic [4:0] s, t,
                      input logic [31:0] sd, td, input logic [15:0] imm);
    in_valid = 1'b1; opcode = op; rs = s; rt = t; rs_data = sd; rt_data = td;
    imm16 = imm; funct = imm[5:0]; shamt = imm[10:6]; rd = imm[15:11];
  endtask

  task automatic fwd_set(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    exmem_we = ew; exmem_rd = er; exmem_data = ed;
    memwb_we = ww; memwb_rd = wr; memwb_data = wd;
  endtask

  initial begin
    bub = '0;
    ill = '0;
    ill.ill = 1'b1;
    reset_n = 1'b0; hold = 1'b0; flush = 1'b0;
    r_op(6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
    in_valid = 1'b0;
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    #12;
    push(bub); check_out("reset");
    check_stall("reset_stall", 1'b0);
    reset_n = 1'b1;

    r_op(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    push(mk(1'b1, 32'd5, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("add");
    i_op(6'h08, 5'd1, 5'd4, 32'd5, 32'd0, 16'hFFFF);
    push(mk(1'b1, 32'd5, 32'hFFFFFFFF, 3'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("addi_sext");
    i_op(6'h0D, 5'd1, 5'd4, 32'd5, 32'd0, 16'hFFFF);
    push(mk(1'b1, 32'd5, 32'h0000FFFF, 3'd5, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("ori_zext");
    r_op(6'h00, 5'd0, 5'd2, 5'd5, 32'h99, 32'h1, 5'd4);
    push(mk(1'b1, 32'h1, 32'h1, 3'd2, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("sll");
    r_op(6'h02, 5'd0, 5'd2, 5'd6, 32'h0, 32'h80, 5'd3);
    push(mk(1'b1, 32'h80, 32'h80, 3'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("srl");

    fwd_set(1'b1, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB);
    r_op(6'h20, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 5'd0);
    push(mk(1'b1, 32'hAA, 32'h22, 3'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("fwd_exmem_prio");
    fwd_set(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    r_op(6'h20, 5'd0, 5'd2, 5'd3, 32'h99, 32'd7, 5'd0);
    push(mk(1'b1, 32'h0, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("fwd_r0");
    fwd_set(1'b0, 5'd7, 32'hEE, 1'b1, 5'd7, 32'hCC);
    r_op(6'h22, 5'd6, 5'd7, 5'd11, 32'd1, 32'd2, 5'd0);
    push(mk(1'b1, 32'd1, 32'hCC, 3'd1, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("fwd_memwb");
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    r_op(6'h2A, 5'd1, 5'd2, 5'd12, 32'hF0F0, 32'hFF00, 5'd0);
    push(mk(1'b1, 32'hF0F0, 32'hFF00, 3'd6, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("slt");
    i_op(6'h0B, 5'd1, 5'd4, 32'd5, 32'd0, 16'h8000);
    push(mk(1'b1, 32'd5, 32'hFFFF8000, 3'd7, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("sltiu");
    i_op(6'h04, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0003);
    push(mk(1'b1, 32'd5, 32'd7, 3'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick("beq");
    i_op(6'h2B, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0010);
    push(mk(1'b1, 32'd5, 32'h10, 3'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick("sw");

    // lw to $t0, then an I-type that only writes $t0: no hazard.
    i_op(6'h23, 5'd1, 5'd8, 32'd5, 32'd0, 16'h0004);
    push(mk(1'b1, 32'd5, 32'd4, 3'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("lw");
    i_op(6'h08, 5'd1, 5'd8, 32'd5, 32'd0, 16'h0001);
    #1 check_stall("no_stall_itype_rt", 1'b0);
    push(mk(1'b1, 32'd5, 32'd1, 3'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("addi_after_lw");

    // lw to $t0 followed by an add reading $t0 through rs.
    i_op(6'h23, 5'd1, 5'd8, 32'd5, 32'd0, 16'h0004);
    push(mk(1'b1, 32'd5, 32'd4, 3'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("lw2");
    r_op(6'h20, 5'd8, 5'd2, 5'd3, 32'hDEAD, 32'd7, 5'd0);
    #1 check_stall("stall_rs", 1'b1);
    push(bub);
    tick("stall_bubble");
    check_stall("stall_released", 1'b0);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
    push(mk(1'b1, 32'h1234, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("held_add_fwd");
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // lw to $t0 followed by sw whose store data is $t0 (rt hazard).
    i_op(6'h23, 5'd1, 5'd8, 32'd5, 32'd0, 16'h0004);
    push(mk(1'b1, 32'd5, 32'd4, 3'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick("lw3");
    i_op(6'h2B, 5'd1, 5'd8, 32'd5, 32'd0, 16'h0010);
    #1 check_stall("stall_rt_sw", 1'b1);
    push(bub);
    tick("stall_bubble_sw");
    push(mk(1'b1, 32'd5, 32'h10, 3'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick("held_sw");

    r_op(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    push(mk(1'b1, 32'd5, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("add_pre_flush");
    flush = 1'b1; hold = 1'b1;
    push(bub);
    tick("flush_over_hold");
    flush = 1'b0; hold = 1'b0;

    r_op(6'h25, 5'd1, 5'd2, 5'd13, 32'd3, 32'd4, 5'd0);
    push(mk(1'b1, 32'd3, 32'd4, 3'd5, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("or_pre_hold");
    hold = 1'b1;
    r_op(6'h22, 5'd4, 5'd5, 5'd14, 32'd9, 32'd2, 5'd0);
    for (int i = 0; i < 3; i++) begin
      push(mk(1'b1, 32'd3, 32'd4, 3'd5, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      tick($sformatf("hold_%0d", i));
    end
    hold = 1'b0;
    push(mk(1'b1, 32'd9, 32'd2, 3'd1, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("after_hold");

    r_op(6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    push(ill);
    tick("illegal_funct");
    i_op(6'h3F, 5'd1, 5'd2, 32'd5, 32'd7, 16'h1234);
    push(ill);
    tick("illegal_opcode");
    r_op(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    in_valid = 1'b0;
    push(bub);
    tick("invalid_bubble");

    r_op(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    push(mk(1'b1, 32'd5, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("add_pre_reset");
    #2 reset_n = 1'b0;
    #1 push(bub);
    check_out("reset_mid");
    #2 reset_n = 1'b1;
    r_op(6'h22, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 5'd0);
    push(mk(1'b1, 32'd9, 32'd4, 3'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick("post_reset_load");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the ALU.
- Decodes opcode/funct into the 3-bit ALU selection code and builds the two ALU operands, including immediate handling and operand forwarding from later stages.
- Detects load-use hazards and registers everything, so the ALU sees stable inputs for a full cycle.
- Downstream consumers are the ALU operand/select/shift inputs and the EX/MEM register.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  decode slot holds a real instruction.
- OPCODE  input  6  instruction[31:26].
- FUNCT  input  6  instruction[5:0].
- SHAMT  input  5  instruction[10:6].
- RS, RT, RD  input  REG_AW each  register indices.
- RS_DATA, RT_DATA  input  DATA_W each  register-file read data.
- IMM16  input  16  instruction[15:0].
- EXMEM_WE, EXMEM_RD, EXMEM_DATA  input  1/REG_AW/DATA_W  EX/MEM writeback info.
- MEMWB_WE, MEMWB_RD, MEMWB_DATA  input  1/REG_AW/DATA_W  MEM/WB writeback info.
- HOLD  input  1  downstream stall; freeze all registers.
- FLUSH  input  1  branch taken; load a bubble.
- OUT_VALID  output  1  registered instruction valid.
- OUT_A, OUT_B  output  DATA_W each  ALU input1/input2.
- OUT_SEL  output  3  ALU selection code.
- OUT_SHAMT  output  5  ALU shift amount.
- OUT_DEST  output  REG_AW  write-back register index.
- OUT_REGWRITE, OUT_MEMREAD, OUT_MEMWRITE, OUT_BRANCH  output  1 each  control flags.
- OUT_ILLEGAL  output  1  registered flag for an unrecognised opcode/funct.
- LOAD_STALL  output  1  combinational; decode must hold its current instruction.

Behaviour:
- Reset (async, RESET_N low): every registered output is 0.
  - OUT_SEL=0, OUT_DEST=0, OUT_A=OUT_B=0, all flags 0.
  - LOAD_STALL follows its combinational equation and reads 0 after reset, because OUT_MEMREAD=0.
- Latency: 1 cycle from decode inputs to registered outputs.
- Select codes: 0 add, 1 sub, 2 sll, 3 srl, 4 and, 5 or, 6 signed less-than, 7 unsigned less-than.
- R-type (OPCODE=0x00), by FUNCT, write dest=RD:
  - 0x20/0x21 ->0; 0x22/0x23 ->1; 0x24 ->4; 0x25 ->5; 0x2A ->6; 0x2B ->7.
  - 0x00 sll ->2 and 0x02 srl ->3: OUT_A = fwd(RT), OUT_SHAMT = SHAMT.
  - Otherwise OUT_A = fwd(RS), OUT_B = fwd(RT), OUT_SHAMT = 0.
- I-type, dest=RT, OUT_A = fwd(RS):
  - Sign-extended IMM16 in OUT_B: addi 0x08 and addiu 0x09 ->0; slti 0x0A ->6; sltiu 0x0B ->7 (compare is unsigned on the sign-extended value).
  - Zero-extended IMM16 in OUT_B: andi 0x0C ->4; ori 0x0D ->5.
  - lw 0x23: ->0, MEMREAD=1, REGWRITE=1.
  - sw 0x2B: ->0, MEMWRITE=1, REGWRITE=0.
  - beq 0x04: ->1, OUT_B = fwd(RT), BRANCH=1, REGWRITE=0.
- Any other opcode/funct: load a bubble (VALID=0, all controls 0) and set OUT_ILLEGAL=1 for one cycle.
- Forwarding fwd(r):
  - r==0 -> 0, never forwarded.
  - else if EXMEM_WE and EXMEM_RD==r -> EXMEM_DATA.
  - else if MEMWB_WE and MEMWB_RD==r -> MEMWB_DATA.
  - else the register-file data. EX/MEM has priority.
- Load-use stall: LOAD_STALL = OUT_VALID & OUT_MEMREAD & OUT_DEST!=0 & IN_VALID & (OUT_DEST==RS | (OUT_DEST==RT & instruction reads RT)).
  - Reads RT: R-type, sw, beq.
  - When LOAD_STALL=1 the stage loads a bubble next cycle.
- Update priority per edge: FLUSH (bubble) > HOLD (keep all) > LOAD_STALL (bubble) > normal load.
  - FLUSH with HOLD: the flush wins.
  - IN_VALID=0 loads a bubble.
- A bubble clears VALID, REGWRITE, MEMREAD, MEMWRITE, BRANCH and ILLEGAL. Data fields hold don't-care values, but the implementation must drive them to 0.
- Reset mid-operation: outputs clear immediately. The first post-reset edge loads normally.

Test Plan:
- add: RS=1 (data 5), RT=2 (data 7), RD=3, FUNCT=0x20 -> next cycle OUT_A=5, OUT_B=7, OUT_SEL=0, OUT_DEST=3, REGWRITE=1.
- addi sign extend: IMM16=0xFFFF -> OUT_B=0xFFFFFFFF. ori zero extend: IMM16=0xFFFF -> OUT_B=0x0000FFFF, OUT_SEL=5.
- sll with SHAMT=4, RT data 0x1 -> OUT_A=0x1, OUT_SHAMT=4, OUT_SEL=2.
- Forwarding with RS=8: EXMEM_RD=8 (data 0xAA) and MEMWB_RD=8 (data 0xBB) both writing -> OUT_A=0xAA. RS=0 with EXMEM_RD=0 -> OUT_A=0.
- lw to $t0 followed by add reading $t0 -> LOAD_STALL=1 for one cycle and a bubble (OUT_VALID=0). The held add issues the next cycle with forwarded data.
- FLUSH and HOLD both high -> OUT_VALID=0. HOLD alone for 3 cycles -> outputs unchanged. RESET_N low mid-stream -> all outputs 0 immediately. FUNCT=0x3F -> OUT_ILLEGAL=1, OUT_VALID=0.
